// File: rtl/fxp8s_stream_accum.sv
// rtl/fxp8s_stream_accum.sv - burst accumulator for fxp8s sign-magnitude samples with saturated fxp8s result
module fxp8s_stream_accum #(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Symmetric clamp limits, one bit wider than the accumulator so acc+x never wraps.
  localparam logic signed [ACC_W:0] SUM_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN  = -SUM_MAX;
  localparam logic [CNT_W-1:0]      LEN_LAST = CNT_W'(MAX_LEN - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic signed [ACC_W:0]   x_mag, x_val, sum_raw, sum_cl, sum_abs;
  logic                    clamp, sum_neg, big, accept, terminal;
  logic [7:0]              res_data;
  logic                    res_sat;

  // Datapath: sample conversion, clamped sum and fxp8s result encoding.
  always_comb begin
    x_mag   = {{(ACC_W-6){1'b0}}, in_data[6:0]};
    x_val   = in_data[7] ? -x_mag : x_mag;
    sum_raw = {acc_q[ACC_W-1], acc_q} + x_val;
    clamp   = 1'b0;
    sum_cl  = sum_raw;
    if (sum_raw > SUM_MAX) begin
      sum_cl = SUM_MAX;
      clamp  = 1'b1;
    end else if (sum_raw < SUM_MIN) begin
      sum_cl = SUM_MIN;
      clamp  = 1'b1;
    end
    sum_neg  = sum_cl[ACC_W];
    sum_abs  = sum_neg ? -sum_cl : sum_cl;
    big      = |sum_abs[ACC_W:7];
    res_data = big ? {sum_neg, 7'h7F} : {sum_neg, sum_abs[6:0]};
    res_sat  = big | sat_q | clamp;
    accept   = in_valid & in_ready_q;
    terminal = accept & (in_last | (cnt_q == LEN_LAST));
  end

  // Next-state logic: accumulate beats, register the result on the terminal beat, hold until taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (terminal) begin
          out_data_d  = res_data;
          out_sat_d   = res_sat;
          out_count_d = cnt_q + 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d   = sum_cl[ACC_W-1:0];
          cnt_d   = cnt_q + 1'b1;
          sat_d   = sat_q | clamp;
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  // State and output registers; reset discards any partial burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fxp8s_stream_accum.sv
// tb/tb_fxp8s_stream_accum.sv - directed scoreboard bench for fxp8s_stream_accum
module tb_fxp8s_stream_accum;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic [8:0] c;
  } res_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic [8:0] out_count;

  int   tests = 0;
  int   fails = 0;
  res_t exp_q[$];

  fxp8s_stream_accum #(.ACC_W(16), .MAX_LEN(256), .CNT_W(9)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("beat_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    int   w;
    res_t e;
    @(negedge clk);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h7F;
      in_last  = 1'b1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_data"}, {24'd0, out_data}, {24'd0, e.d});
      check({tag, "_hold_count"}, {23'd0, out_count}, {23'd0, e.c});
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, e.d});
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, e.s});
    check({tag, "_count"}, {23'd0, out_count}, {23'd0, e.c});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_count", {23'd0, out_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Mixed signs, with the one-cycle latency checked right after the last beat.
    exp_q.push_back('{d: 8'h10, s: 1'b0, c: 9'd3});
    beat(8'h08, 1'b0);
    beat(8'h10, 1'b0);
    check("mixed_pre_valid", {31'd0, out_valid}, 32'd0);
    beat(8'h88, 1'b1);
    check("mixed_latency", {31'd0, out_valid}, 32'd1);
    get_result("mixed", 0);

    // Positive and negative output saturation.
    exp_q.push_back('{d: 8'h7F, s: 1'b1, c: 9'd4});
    for (int i = 0; i < 4; i++) beat(8'h7F, i == 3);
    get_result("sat_pos", 0);
    exp_q.push_back('{d: 8'hFF, s: 1'b1, c: 9'd4});
    for (int i = 0; i < 4; i++) beat(8'hFF, i == 3);
    get_result("sat_neg", 0);

    // Cancellation to zero including a negative-zero sample.
    exp_q.push_back('{d: 8'h00, s: 1'b0, c: 9'd3});
    beat(8'h85, 1'b0);
    beat(8'h05, 1'b0);
    beat(8'h80, 1'b1);
    get_result("negzero", 0);

    // Backpressure: result held five cycles while ignored beats are offered.
    exp_q.push_back('{d: 8'h10, s: 1'b0, c: 9'd2});
    beat(8'h08, 1'b0);
    beat(8'h08, 1'b1);
    get_result("backpr", 5);

    // Forced termination at MAX_LEN, then a fresh burst from zero.
    exp_q.push_back('{d: 8'h7F, s: 1'b1, c: 9'd256});
    for (int i = 0; i < 256; i++) beat(8'h01, 1'b0);
    get_result("maxlen", 0);
    exp_q.push_back('{d: 8'h08, s: 1'b0, c: 9'd1});
    beat(8'h08, 1'b1);
    get_result("after_max", 0);

    // Asynchronous reset mid-burst between clock edges.
    beat(8'h7F, 1'b0);
    beat(8'h7F, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_out_sat", {31'd0, out_sat}, 32'd0);
    check("arst_out_count", {23'd0, out_count}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_result", {31'd0, out_valid}, 32'd0);
    end
    exp_q.push_back('{d: 8'h18, s: 1'b0, c: 9'd1});
    beat(8'h18, 1'b1);
    get_result("after_rst", 0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fxp8s_stream_accum.md
Name: fxp8s_stream_accum

Overview:
- Downstream consumer of the fxp8s variable shifter output stream.
- Accepts 8-bit sign-magnitude fixed-point samples (bit 7 sign, bits 6:0 magnitude, LSB weight 2^-3) under a valid/ready handshake.
- Sums each burst (terminated by in_last or by MAX_LEN beats) in a wide two's-complement accumulator.
- Emits one saturated fxp8s result per burst, with a saturation flag and a beat count.

Parameters:
- ACC_W, 16, accumulator width in bits, two's complement; must be at least 9.
- MAX_LEN, 256, maximum number of beats per burst; the burst is force-terminated when this count is reached.
- CNT_W, 9, width of the beat counter and of out_count; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept an input sample.
- in_data  input  8  fxp8s sample: [7] sign, [6:0] magnitude.
- in_last  input  1  final beat of the burst; sampled only on an accepted beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8  fxp8s burst sum, saturated.
- out_sat  output  1  result or accumulator saturated during the burst.
- out_count  output  CNT_W  number of beats in the burst (1..MAX_LEN).

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; acc, cnt, sat_sticky cleared.
  - out_valid=0, out_data=0x00, out_sat=0, out_count=0, in_ready=0 while rstn is low.
  - Reset mid-burst or mid-hold discards all partial data. No result is emitted for the interrupted burst.
- Beat acceptance: in_valid & in_ready on a rising edge. in_ready = (state != HOLD) after reset.
- Input conversion: x = {0, in_data[6:0]} zero-extended to ACC_W, then negated if in_data[7]=1. Negative zero (0x80) equals 0.
- Accumulate: sum = acc + x.
  - The sum is clamped to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
  - A clamp sets sat_sticky.
- States:
  - IDLE: waiting for the first beat. On an accepted beat go to ACCUM, or directly to HOLD if that beat is terminal.
  - ACCUM: each accepted beat updates acc and increments cnt.
  - HOLD: result registered, in_ready=0, out_valid=1.
- Terminal beat: an accepted beat with in_last=1, or the beat that makes cnt+1 == MAX_LEN. On the terminal beat:
  - The result is computed from the clamped sum (acc+x) and registered.
  - out_count = cnt+1.
  - acc, cnt and sat_sticky are cleared in the same cycle.
  - Next state is HOLD.
- Output conversion:
  - sign = (sum < 0). mag = |sum|.
  - If mag > 127: out_data = {sign, 7'h7F} and out_sat=1.
  - Otherwise out_data = {sign, mag[6:0]} and out_sat = sat_sticky.
  - A zero sum always yields 0x00. The block never emits 0x80.
- Latency: out_valid rises the cycle after the terminal beat is accepted.
- HOLD:
  - out_data, out_sat and out_count are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_valid drops next cycle, state goes to IDLE, and in_ready=1 the next cycle.
  - There is no input/output overlap: one bubble per burst.
- in_valid low inside a burst: acc and cnt are held, and the state stays ACCUM indefinitely.
- in_last on a beat that also reaches MAX_LEN: a single termination only.
- Inputs are ignored when in_ready=0, including in_last.
- All outputs are registered; no combinational path from in_* to out_*.

Test Plan:
- Mixed signs: 0x08, 0x10, 0x88(last) = +1.0, +2.0, -1.0 -> out_data=0x10 (2.0), out_sat=0, out_count=3, out_valid one cycle after the last beat.
- Output saturation:
  - 4 beats 0x7F (last on 4th) -> sum 508 -> out_data=0x7F, out_sat=1, out_count=4.
  - Same with 0xFF -> out_data=0xFF, out_sat=1.
- Cancellation and negative zero: 0x85, 0x05, 0x80(last) -> out_data=0x00 (never 0x80), out_sat=0, out_count=3.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and out_count stable, in_ready=0, and in_valid beats are ignored.
  - Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Forced termination: MAX_LEN=256, 256 beats of 0x01 with in_last=0 -> result after beat 256: sum 256 -> out_data=0x7F, out_sat=1, out_count=256. The next burst starts from acc=0.
- Async reset:
  - Assert rstn=0 between clock edges after 2 beats of a burst -> outputs clear immediately.
  - After release, the burst 0x18(last) -> out_data=0x18, out_count=1 (no residue from the aborted burst).
